// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: output mode encodings,
// {R,G,B} colour selectors with their expansion to COLOR_W-bit channels,
// and the default 640x480@60 timing constants.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_EXT   = 2'd0,
      MODE_GRID  = 2'd1,
      MODE_BARS  = 2'd2,
      MODE_CHECK = 2'd3
   } mode_e;

   // Default 640x480@60 timing (pixels / lines)
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   // Widest colour channel the expansion function supports
   localparam int MAX_COLOR_W = 8;

   // Colour selectors: one enable bit per channel, ordered {R,G,B}
   localparam logic [2:0] BLACK   = 3'b000;
   localparam logic [2:0] BLUE    = 3'b001;
   localparam logic [2:0] GREEN   = 3'b010;
   localparam logic [2:0] CYAN    = 3'b011;
   localparam logic [2:0] RED     = 3'b100;
   localparam logic [2:0] MAGENTA = 3'b101;
   localparam logic [2:0] YELLOW  = 3'b110;
   localparam logic [2:0] WHITE   = 3'b111;

   // Expands a selector to {R,G,B} with cw bits per channel, each enabled
   // channel at full scale. Result sits in the low 3*cw bits.
   function automatic logic [3*MAX_COLOR_W-1:0] colour(input logic [2:0] sel, input int cw);
      logic [3*MAX_COLOR_W-1:0] ch;
      logic [3*MAX_COLOR_W-1:0] res;
      ch  = {(3*MAX_COLOR_W){1'b1}} >> (3*MAX_COLOR_W - cw);
      res = sel[2] ? ch : '0;
      res = (res << cw) | (sel[1] ? ch : '0);
      res = (res << cw) | (sel[0] ? ch : '0);
      return res;
   endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational pixel colour source: external pass-through, grid, colour bars
// or checkerboard, selected by the frame-shadowed mode. No latency, no flow control.
// Ports: h_i/v_i pixel coordinate, mode_i shadowed mode, rgb_i external pixel, rgb_o colour.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int CNT_W     = 10,
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int COLOR_W   = 2,
   parameter int GRID_STEP = 80
) (
   input  logic [CNT_W-1:0]     h_i,
   input  logic [CNT_W-1:0]     v_i,
   input  mode_e                mode_i,
   input  logic [3*COLOR_W-1:0] rgb_i,
   output logic [3*COLOR_W-1:0] rgb_o
);

   // Bar width degenerates to 1 for tiny test geometries so the divide stays legal
   localparam int BAR_W = (H_VISIBLE >= 8) ? (H_VISIBLE / 8) : 1;

   localparam logic [CNT_W-1:0] GRID_C = CNT_W'(GRID_STEP);
   localparam logic [CNT_W-1:0] BAR_C  = CNT_W'(BAR_W);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE - 1);
   localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(7);

   logic             grid_line;
   logic             border;
   logic [CNT_W-1:0] bar_idx;
   logic [2:0]       bar_sel;
   logic [2:0]       sel;

   always_comb begin
      grid_line = (((h_i % GRID_C) == '0) && (h_i != '0)) ||
                  (((v_i % GRID_C) == '0) && (v_i != '0));
      border    = (h_i == '0) || (h_i == H_LAST) || (v_i == '0) || (v_i == V_LAST);

      // Remainder pixels past the eighth bar stay in the last (black) bar
      bar_idx = h_i / BAR_C;
      bar_sel = (bar_idx > BAR_MAX) ? 3'd7 : bar_idx[2:0];

      sel = BLACK;
      case (mode_i)
         MODE_GRID:  sel = grid_line ? GREEN : (border ? WHITE : BLACK);
         MODE_BARS: begin
            case (bar_sel)
               3'd0:    sel = WHITE;
               3'd1:    sel = YELLOW;
               3'd2:    sel = CYAN;
               3'd3:    sel = GREEN;
               3'd4:    sel = MAGENTA;
               3'd5:    sel = RED;
               3'd6:    sel = BLUE;
               default: sel = BLACK;
            endcase
         end
         MODE_CHECK: sel = (h_i[0] ^ v_i[0]) ? WHITE : BLACK;
         default:    sel = BLACK;
      endcase

      rgb_o = (mode_i == MODE_EXT) ? rgb_i : (3*COLOR_W)'(colour(sel, COLOR_W));
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with clock divider, frame-shadowed pattern mode and a
// one-pixel registered output stage; latency one pixel (CLK_DIV clk); no backpressure,
// the DAC side always accepts. Ports: clk/rst, mode, rgb_in (combinational for cnt_h/cnt_v)
// in; pix_ce, cnt_h/cnt_v, vga_sync_h/v, vga_de, vga_rgb, frame_start, line_start out.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter int CNT_W     = 10,
   parameter int CLK_DIV   = 2,
   parameter bit H_POL     = 1'b0,
   parameter bit V_POL     = 1'b0,
   parameter int COLOR_W   = 2,
   parameter int GRID_STEP = 80
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic [3*COLOR_W-1:0] rgb_in,
   output logic                 pix_ce,
   output logic [CNT_W-1:0]     cnt_h,
   output logic [CNT_W-1:0]     cnt_v,
   output logic                 vga_sync_h,
   output logic                 vga_sync_v,
   output logic                 vga_de,
   output logic [3*COLOR_W-1:0] vga_rgb,
   output logic                 frame_start,
   output logic                 line_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

   logic [DIV_W-1:0]     div_q, div_d;
   logic [CNT_W-1:0]     cnt_h_q, cnt_h_d;
   logic [CNT_W-1:0]     cnt_v_q, cnt_v_d;
   mode_e                mode_q, mode_d;
   logic                 sync_h_q, sync_h_d;
   logic                 sync_v_q, sync_v_d;
   logic                 de_q, de_d;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;
   logic                 fs_q, fs_d;
   logic                 ls_q, ls_d;

   logic                 h_wrap;
   logic [3*COLOR_W-1:0] pat_rgb;

   // Gated with rst so the strobe is low throughout reset even when CLK_DIV=1
   assign pix_ce = ~rst & (div_q == DIV_LAST);

   vga_pattern_gen #(
      .CNT_W     (CNT_W),
      .H_VISIBLE (H_VISIBLE),
      .V_VISIBLE (V_VISIBLE),
      .COLOR_W   (COLOR_W),
      .GRID_STEP (GRID_STEP)
   ) u_pattern (
      .h_i    (cnt_h_q),
      .v_i    (cnt_v_q),
      .mode_i (mode_q),
      .rgb_i  (rgb_in),
      .rgb_o  (pat_rgb)
   );

   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

      h_wrap  = (cnt_h_q == H_LAST);
      cnt_h_d = h_wrap ? '0 : cnt_h_q + 1'b1;
      cnt_v_d = cnt_v_q;
      if (h_wrap) begin
         cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 1'b1;
      end

      // Mode is only taken on the last pixel of a frame, so (0,0) onwards uses it
      mode_d = (h_wrap && (cnt_v_q == V_LAST)) ? mode_e'(mode) : mode_q;

      de_d     = (cnt_h_q < H_VIS_C) && (cnt_v_q < V_VIS_C);
      sync_h_d = ((cnt_h_q >= HS_START) && (cnt_h_q < HS_END)) ? H_POL : ~H_POL;
      sync_v_d = ((cnt_v_q >= VS_START) && (cnt_v_q < VS_END)) ? V_POL : ~V_POL;
      rgb_d    = de_d ? pat_rgb : '0;
      fs_d     = (cnt_h_q == '0) && (cnt_v_q == '0);
      ls_d     = (cnt_h_q == '0) && (cnt_v_q < V_VIS_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q    <= '0;
         cnt_h_q  <= '0;
         cnt_v_q  <= '0;
         mode_q   <= MODE_EXT;
         sync_h_q <= ~H_POL;
         sync_v_q <= ~V_POL;
         de_q     <= 1'b0;
         rgb_q    <= '0;
         fs_q     <= 1'b0;
         ls_q     <= 1'b0;
      end else begin
         div_q <= div_d;
         if (pix_ce) begin
            cnt_h_q  <= cnt_h_d;
            cnt_v_q  <= cnt_v_d;
            mode_q   <= mode_d;
            sync_h_q <= sync_h_d;
            sync_v_q <= sync_v_d;
            de_q     <= de_d;
            rgb_q    <= rgb_d;
            fs_q     <= fs_d;
            ls_q     <= ls_d;
         end
      end
   end

   assign cnt_h       = cnt_h_q;
   assign cnt_v       = cnt_v_q;
   assign vga_sync_h  = sync_h_q;
   assign vga_sync_v  = sync_v_q;
   assign vga_de      = de_q;
   assign vga_rgb     = rgb_q;
   assign frame_start = fs_q;
   assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: instance A keeps the 640-pixel line but a short 8-line frame
// (CLK_DIV=2, active-low syncs); instance B is a tiny active-high, CLK_DIV=1 variant.
module tb_vga_timing_gen;

   localparam int HT = 800;
   localparam int VT = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // ---------------- instance A ----------------
   logic [1:0] mode_a;
   logic [5:0] rgb_in_a;
   logic       pix_ce_a, vga_sync_h_a, vga_sync_v_a, vga_de_a, frame_start_a, line_start_a;
   logic [9:0] cnt_h_a, cnt_v_a;
   logic [5:0] vga_rgb_a;

   // External pixel depends on the live coordinate so alignment is visible
   assign rgb_in_a = cnt_h_a[5:0] ^ 6'h15;

   vga_timing_gen #(
      .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CNT_W(10), .CLK_DIV(2), .H_POL(1'b0), .V_POL(1'b0),
      .COLOR_W(2), .GRID_STEP(80)
   ) dut_a (
      .clk(clk), .rst(rst), .mode(mode_a), .rgb_in(rgb_in_a),
      .pix_ce(pix_ce_a), .cnt_h(cnt_h_a), .cnt_v(cnt_v_a),
      .vga_sync_h(vga_sync_h_a), .vga_sync_v(vga_sync_v_a), .vga_de(vga_de_a),
      .vga_rgb(vga_rgb_a), .frame_start(frame_start_a), .line_start(line_start_a)
   );

   // ---------------- instance B ----------------
   logic [1:0] mode_b = 2'd0;
   logic [5:0] rgb_in_b = 6'h2A;
   logic       pix_ce_b, vga_sync_h_b, vga_sync_v_b, vga_de_b, frame_start_b, line_start_b;
   logic [4:0] cnt_h_b, cnt_v_b;
   logic [5:0] vga_rgb_b;

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CNT_W(5), .CLK_DIV(1), .H_POL(1'b1), .V_POL(1'b1),
      .COLOR_W(2), .GRID_STEP(4)
   ) dut_b (
      .clk(clk), .rst(rst), .mode(mode_b), .rgb_in(rgb_in_b),
      .pix_ce(pix_ce_b), .cnt_h(cnt_h_b), .cnt_v(cnt_v_b),
      .vga_sync_h(vga_sync_h_b), .vga_sync_v(vga_sync_v_b), .vga_de(vga_de_b),
      .vga_rgb(vga_rgb_b), .frame_start(frame_start_b), .line_start(line_start_b)
   );

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bench-side coordinate of the next pixel instance A will output
   int ph = 0, pv = 0;
   int cur_h = 0, cur_v = 0;

   // Advance A by one pixel; on return the outputs show pixel (cur_h, cur_v)
   task automatic step();
      int n = 0;
      while (pix_ce_a !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (pix_ce_a !== 1'b1) begin
         chk("pix_ce_timeout", 32'(pix_ce_a), 1);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $fatal(1, "pix_ce strobe never arrived");
      end
      @(posedge clk);
      #1;
      cur_h = ph;
      cur_v = pv;
      ph++;
      if (ph == HT) begin
         ph = 0;
         pv++;
         if (pv == VT) pv = 0;
      end
   endtask

   task automatic goto(input int h, input int v);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(cur_h == h && cur_v == v) && n < 2*HT*VT);
   endtask

   task automatic chk_reset_a(input string pfx);
      chk({pfx, "_sync_h"}, 32'(vga_sync_h_a), 1);
      chk({pfx, "_sync_v"}, 32'(vga_sync_v_a), 1);
      chk({pfx, "_de"}, 32'(vga_de_a), 0);
      chk({pfx, "_rgb"}, 32'(vga_rgb_a), 0);
      chk({pfx, "_fs"}, 32'(frame_start_a), 0);
      chk({pfx, "_ls"}, 32'(line_start_a), 0);
      chk({pfx, "_pix_ce"}, 32'(pix_ce_a), 0);
      chk({pfx, "_cnt_h"}, 32'(cnt_h_a), 0);
      chk({pfx, "_cnt_v"}, 32'(cnt_v_a), 0);
   endtask

   // ---------------- instance A sequence ----------------
   initial begin
      int hs_cnt, hs_first, hs_last, de_cnt;
      int fs_cnt, ls_cnt, vs_lines, vs_first, de_frame;

      rst    = 1'b1;
      mode_a = 2'd2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_a("rst0");

      rst = 1'b0;
      #1;
      chk("ce_at_release", 32'(pix_ce_a), 0);
      @(negedge clk);
      chk("ce_first", 32'(pix_ce_a), 1);
      chk("cnt_h_first", 32'(cnt_h_a), 0);
      chk("cnt_v_first", 32'(cnt_v_a), 0);
      ph = 0;
      pv = 0;

      // Frame 0, line 0: external mode (mode_q resets to 0)
      hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0;
      for (int i = 0; i < HT; i++) begin
         step();
         if (vga_sync_h_a == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         if (vga_de_a) de_cnt++;
         if (i == 0) begin
            chk("fs_p00", 32'(frame_start_a), 1);
            chk("ls_p00", 32'(line_start_a), 1);
         end
         if (i == 1) chk("fs_p10", 32'(frame_start_a), 0);
         if (i == 5) chk("ext_rgb_p5", 32'(vga_rgb_a), 32'h10);
      end
      chk("hsync_len", 32'(hs_cnt), 96);
      chk("hsync_first", 32'(hs_first), 656);
      chk("hsync_last", 32'(hs_last), 751);
      chk("de_line", 32'(de_cnt), 640);

      // Rest of frame 0
      fs_cnt = 0; ls_cnt = 0; vs_lines = 0; vs_first = -1; de_frame = 0;
      for (int i = HT; i < HT*VT; i++) begin
         step();
         if (frame_start_a) fs_cnt++;
         if (line_start_a) ls_cnt++;
         if (vga_de_a) de_frame++;
         if (cur_h == 0 && vga_sync_v_a == 1'b0) begin
            vs_lines++;
            if (vs_first < 0) vs_first = cur_v;
         end
      end
      chk("fs_rest", 32'(fs_cnt), 0);
      chk("ls_rest", 32'(ls_cnt), 3);
      chk("de_rest", 32'(de_frame), 1920);
      chk("vsync_lines", 32'(vs_lines), 2);
      chk("vsync_first", 32'(vs_first), 5);

      // Pixel cadence: one strobe every second clk
      @(negedge clk);
      chk("ce_gap", 32'(pix_ce_a), 0);
      @(negedge clk);
      chk("ce_period", 32'(pix_ce_a), 1);

      // Frame 1: colour bars
      step();
      chk("bars_p0", 32'(vga_rgb_a), 32'h3F);
      chk("fs_frame1", 32'(frame_start_a), 1);
      goto(80, 0);
      chk("bars_p80", 32'(vga_rgb_a), 32'h3C);
      goto(160, 0);
      chk("bars_p160", 32'(vga_rgb_a), 32'h0F);
      goto(639, 0);
      chk("bars_p639", 32'(vga_rgb_a), 0);
      chk("de_p639", 32'(vga_de_a), 1);
      step();
      chk("de_p640", 32'(vga_de_a), 0);
      chk("rgb_p640", 32'(vga_rgb_a), 0);
      goto(0, 1);
      mode_a = 2'd1;
      goto(80, 2);
      chk("bars_hold", 32'(vga_rgb_a), 32'h3C);

      // Frame 2: grid, with a switch to checkerboard mid-frame
      goto(0, 1);
      mode_a = 2'd3;
      goto(5, 2);
      chk("grid_p5_2", 32'(vga_rgb_a), 0);
      goto(80, 2);
      chk("grid_p80_2", 32'(vga_rgb_a), 32'h0C);
      goto(639, 2);
      chk("grid_p639_2", 32'(vga_rgb_a), 32'h3F);

      // Frame 3: checkerboard
      goto(0, 0);
      chk("check_p00", 32'(vga_rgb_a), 0);
      chk("fs_frame3", 32'(frame_start_a), 1);
      step();
      chk("check_p10", 32'(vga_rgb_a), 32'h3F);

      // Mid-frame asynchronous reset
      goto(300, 2);
      rst = 1'b1;
      #1;
      chk_reset_a("rst_mid");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ce_rel2", 32'(pix_ce_a), 0);
      @(negedge clk);
      chk("ce_first2", 32'(pix_ce_a), 1);
      chk("cnt_h_first2", 32'(cnt_h_a), 0);
      chk("cnt_v_first2", 32'(cnt_v_a), 0);
      ph = 0;
      pv = 0;
      step();
      chk("fs_after_rst", 32'(frame_start_a), 1);
      chk("ls_after_rst", 32'(line_start_a), 1);
      chk("de_after_rst", 32'(vga_de_a), 1);
      chk("rgb_after_rst", 32'(vga_rgb_a), 32'h15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // ---------------- instance B: polarity and CLK_DIV=1 ----------------
   initial begin
      int lo, hs, hs_first, vs, de, fs;
      #5;
      chk("b_rst_sync_h", 32'(vga_sync_h_b), 0);
      chk("b_rst_sync_v", 32'(vga_sync_v_b), 0);
      chk("b_rst_pix_ce", 32'(pix_ce_b), 0);
      chk("b_rst_cnt", 32'({cnt_h_b, cnt_v_b}), 0);
      @(negedge rst);
      #1;
      chk("b_ce_release", 32'(pix_ce_b), 1);
      lo = 0; hs = 0; hs_first = -1; vs = 0; de = 0; fs = 0;
      // Sample i shows pixel (i%16, i/16)
      for (int i = 0; i < 128; i++) begin
         @(posedge clk);
         #1;
         if (!pix_ce_b) lo++;
         if (vga_sync_h_b && i < 16) begin
            hs++;
            if (hs_first < 0) hs_first = i;
         end
         if (vga_sync_v_b) vs++;
         if (vga_de_b) de++;
         if (frame_start_b) fs++;
         if (i == 0) chk("b_rgb_p0", 32'(vga_rgb_b), 32'h2A);
         if (i == 8) chk("b_rgb_p8", 32'(vga_rgb_b), 0);
         if (i == 16) chk("b_ls_line1", 32'(line_start_b), 1);
      end
      chk("b_ce_low", 32'(lo), 0);
      chk("b_hsync_len", 32'(hs), 3);
      chk("b_hsync_first", 32'(hs_first), 10);
      chk("b_vsync_pix", 32'(vs), 32);
      chk("b_de_pix", 32'(de), 32);
      chk("b_fs_cnt", 32'(fs), 1);
   end

endmodule
